// File: rtl/rv32_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv32_decode_queue
// Purpose  : Fetch-to-decode instruction buffer. It replaces the single
//            pipeline register with a DEPTH-entry circular FIFO. Each entry
//            holds the pc, the instruction word, the fetch exception flag and
//            cause, and the branch-prediction bit. Fetch keeps running while
//            decode is stalled. A flush empties the queue in one cycle.
// Ports    : clk, reset (sync, active-high)
//            flush_in, stall_in          - hazard-unit controls
//            valid_in / ready_out        - fetch-side handshake
//            pc_in, instr_in, exception_in, exception_cause_in,
//            branch_predicted_taken_in   - entry fields from fetch
//            valid_out, pc_out, instr_out, exception_out,
//            exception_cause_out,
//            branch_predicted_taken_out  - head entry toward decode
//            count_out                   - current occupancy
// Options  : RV32_DECODE_QUEUE_BYPASS_EN - when defined, an empty queue
//            forwards the fetch entry to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_decode_queue #(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_in,
  input  logic                         stall_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [INSTR_WIDTH-1:0]       instr_in,
  input  logic                         exception_in,
  input  logic [3:0]                   exception_cause_in,
  input  logic                         branch_predicted_taken_in,
  output logic                         valid_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [INSTR_WIDTH-1:0]       instr_out,
  output logic                         exception_out,
  output logic [3:0]                   exception_cause_out,
  output logic                         branch_predicted_taken_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = $clog2(DEPTH+1);
  // Entry layout, MSB to LSB: pc | instr | exception | cause | prediction
  localparam int C_ENTRY_W = PC_WIDTH + INSTR_WIDTH + 1 + 4 + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [C_ENTRY_W-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_CNT_W-1:0]   r_count;

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic                 w_empty;
  logic                 w_ready;
  logic                 w_bypass;   // outputs show the fetch entry directly
  logic                 w_consume;  // bypassed entry taken by decode, never stored
  logic                 w_push;
  logic                 w_pop;
  logic [C_ENTRY_W-1:0] w_in_entry;
  logic [C_ENTRY_W-1:0] w_head;
  logic [C_ENTRY_W-1:0] w_out_entry;

  assign w_empty    = (r_count == '0);
  // Full check uses only registered state: a pop in the same cycle does not
  // open a slot for fetch, which keeps ready_out free of decode timing.
  assign w_ready    = (r_count != C_FULL);
  assign w_in_entry = {pc_in, instr_in, exception_in, exception_cause_in,
                       branch_predicted_taken_in};
  assign w_head     = r_mem[r_rd_ptr];

`ifdef RV32_DECODE_QUEUE_BYPASS_EN
  assign w_bypass  = w_empty && valid_in;
  assign w_consume = w_bypass && !stall_in && !flush_in;
`else
  assign w_bypass  = 1'b0;
  assign w_consume = 1'b0;
`endif

  assign w_push = valid_in && w_ready && !flush_in && !w_consume;
  // A bypassed entry never occupies storage, so only a stored head can pop.
  assign w_pop  = !w_empty && !stall_in && !flush_in;

  // Empty queue drives zeros on every data field so decode never sees stale
  // or uninitialised storage.
  always_comb begin
    w_out_entry = '0;
    if (w_bypass) begin
      w_out_entry = w_in_entry;
    end else if (!w_empty) begin
      w_out_entry = w_head;
    end
  end

  assign ready_out  = w_ready;
  assign valid_out  = !w_empty || w_bypass;
  assign count_out  = r_count;
  assign {pc_out, instr_out, exception_out, exception_cause_out,
          branch_predicted_taken_out} = w_out_entry;

  // --------------------------------------------------------------------------
  // Storage write (data only; validity is tracked by the pointers/count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. Reset and flush both empty the queue; pointers
  // wrap by natural overflow since DEPTH is a power of two.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_decode_queue
// Purpose  : Self-checking bench for rv32_decode_queue (default build).
//            An issue-side process appends every entry the queue should
//            accept to an expected-order list; a monitor compares the DUT
//            head, occupancy and handshake against that list each cycle and
//            retires entries that decode takes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_decode_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  cause;
    logic        bp;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in;
  logic        stall_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        exception_in;
  logic [3:0]  exception_cause_in;
  logic        branch_predicted_taken_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        exception_out;
  logic [3:0]  exception_cause_out;
  logic        branch_predicted_taken_out;
  logic [2:0]  count_out;

  int     vectors     = 0;
  int     miscompares = 0;
  bit     started     = 1'b0;
  int     mon_occ     = 0;
  entry_t exp_q[$];

  always #5 clk = ~clk;

  rv32_decode_queue #(
    .DEPTH       (DEPTH),
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .flush_in                   (flush_in),
    .stall_in                   (stall_in),
    .valid_in                   (valid_in),
    .ready_out                  (ready_out),
    .pc_in                      (pc_in),
    .instr_in                   (instr_in),
    .exception_in               (exception_in),
    .exception_cause_in         (exception_cause_in),
    .branch_predicted_taken_in  (branch_predicted_taken_in),
    .valid_out                  (valid_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .count_out                  (count_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Issue side: at each edge decide what the queue must accept, from the
  // occupancy the monitor observed for this cycle (a same-cycle pop does not
  // free a slot).
  always @(posedge clk) begin
    if (reset || flush_in) begin
      exp_q.delete();
    end else if (valid_in && mon_occ != DEPTH) begin
      exp_q.push_back('{pc: pc_in, instr: instr_in, exc: exception_in,
                        cause: exception_cause_in, bp: branch_predicted_taken_in});
    end
  end

  // Monitor: compare the presented head, then retire it if decode takes it.
  always @(negedge clk) begin
    int     occ;
    entry_t e;
    occ     = exp_q.size();
    mon_occ = occ;
    if (started) begin
      check("count_out", 64'(count_out), 64'(occ));
      check("ready_out", 64'(ready_out), 64'(occ != DEPTH));
      check("valid_out", 64'(valid_out), 64'(occ != 0));
      e = '0;
      if (occ != 0) e = exp_q[0];
      check("pc_out",    64'(pc_out),                     64'(e.pc));
      check("instr_out", 64'(instr_out),                  64'(e.instr));
      check("exc_out",   64'(exception_out),              64'(e.exc));
      check("cause_out", 64'(exception_cause_out),        64'(e.cause));
      check("bp_out",    64'(branch_predicted_taken_out), 64'(e.bp));
      if (occ != 0 && !stall_in && !flush_in && !reset) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic exc, input logic [3:0] cause, input logic bp,
                       input logic st, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    valid_in                  = v;
    pc_in                     = pc;
    instr_in                  = ins;
    exception_in              = exc;
    exception_cause_in        = cause;
    branch_predicted_taken_in = bp;
    stall_in                  = st;
    flush_in                  = fl;
    reset                     = rs;
  endtask

  task automatic idle(input int n, input logic st);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, st, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush_in = 1'b0; stall_in = 1'b0; valid_in = 1'b0;
    pc_in = '0; instr_in = '0; exception_in = 1'b0; exception_cause_in = '0;
    branch_predicted_taken_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    started = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Single entry, one-cycle latency, then drained
    drive(1'b1, 32'h100, 32'h00000013, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Fill under stall, fifth entry held off until a slot frees
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'(i * 4), 32'h00100093 + 32'(i), 1'b0, 4'h0, i[0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h10, 32'h00500093, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      drive(1'b1, 32'h10, 32'h00500093, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Three buffered, flush with a concurrent push
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h300 + 32'(i * 4), 32'hABCD0000 + 32'(i), 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Exception entry carried like any other
    drive(1'b1, 32'h500, 32'h00000073, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 32'h00000000, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Pointer wrap: back-to-back push/pop pairs
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'(i * 4), 32'h00000013, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Reset mid-operation with a push pending
    for (int i = 0; i < 2; i++)
      drive(1'b1, 32'h600 + 32'(i * 4), 32'h1111, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h700, 32'h2222, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 8) == 0,
            4'($urandom), 1'($urandom), ($urandom % 3) == 0,
            ($urandom % 40) == 0, ($urandom % 200) == 0);
    end
    idle(8, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
